dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port, word-addressed data memory (1024 × REG_BITS, asynchronous read, write on rising CLK). Port 0 serves the core load/store path; port 1 serves a loader/debug master. Each accepted request is converted into word-level memory accesses:
- byte/half/word loads with sign or zero extension;
- full-word stores in one cycle;
- sub-word stores as a two-cycle read-modify-write.

## Interface
Parameters:
- REG_BITS, 32, data and byte-address width.
- MEM_WORDS, 1024, memory depth in words; index width is $clog2(MEM_WORDS).

Ports (p ∈ {0,1}):
- CLK  in  1  clock, all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- Pp_VALID  in  1  request present.
- Pp_READY  out  1  request accepted this cycle when VALID & READY.
- Pp_ADDR  in  REG_BITS  byte address.
- Pp_WE  in  1  1 = store, 0 = load.
- Pp_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- Pp_UNSIGNED  in  1  zero-extend loads when 1, sign-extend when 0.
- Pp_WDATA  in  REG_BITS  store data, right-aligned.
- Pp_RVALID  out  1  one-cycle response pulse (loads and stores).
- Pp_RDATA  out  REG_BITS  load result. 0 for stores and errors.
- Pp_ERR  out  1  qualifies RVALID. Set on misaligned, out-of-range or illegal-size requests.
- MEM_A  out  $clog2(MEM_WORDS)  word index = ADDR[2 +: idx].
- MEM_WD  out  REG_BITS  write word.
- MEM_WE  out  1  write enable.
- MEM_RD  in  REG_BITS  combinational read word.

## Operation
- States are IDLE and RMW.
- **Arbitration (IDLE only):**
  - Round-robin pointer LAST holds the last granted port.
  - If only one port is valid, grant it. If both are valid, grant the port ≠ LAST.
  - READY is combinational: granted port's READY = 1, other = 0.
  - In RMW, both READY = 0.
  - LAST updates on every accept.
- **Error check:**
  - Error conditions:
    - SIZE = 11;
    - half with ADDR[0] = 1;
    - word with ADDR[1:0] ≠ 0;
    - ADDR[REG_BITS-1 : 2+idx] ≠ 0.
  - An errored request is accepted normally, performs no memory write (MEM_WE = 0), and responds ERR = 1, RDATA = 0.
- **Load:**
  - MEM_A is driven during the accept cycle.
  - The addressed lane of MEM_RD is selected by ADDR[1:0], extended, and registered into RDATA.
- **Word store:** MEM_WE = 1, MEM_WD = WDATA during the accept cycle; FSM stays in IDLE.
- **Sub-word store:**
  - Accept cycle: MEM_A is driven and MEM_RD is latched into OLD. Address, size, data and port are also registered. FSM goes to RMW.
  - RMW cycle: MEM_A = registered index, MEM_WE = 1, MEM_WD = OLD with the addressed byte/half replaced by the low bits of WDATA.
  - RMW → IDLE unconditionally.
- Responses have no backpressure; requesters must accept RVALID.

## Timing
- Reset values: all READY/RVALID/ERR/MEM_WE = 0, RDATA = 0, state IDLE, LAST = 1 (port 0 wins the first conflict).
- While RST is high, READY = 0.
- Latency, accept at cycle T:
  - load, word store, errored request: RVALID at T+1.
  - sub-word store: memory write at end of T+1, RVALID at T+2.
- Throughput: one request per cycle in IDLE. A sub-word store blocks both ports for one cycle.
- A store accepted at T is visible to a load accepted at T+1 (write lands at end of T). For RMW the write lands at end of T+1, and a load accepted at T+2 sees it.
- RST asserted during RMW: the pending write is dropped, no RVALID is issued, and the FSM returns to IDLE.
- A requester must hold VALID and its payload stable until READY.

## Structure
- Package dmem_pkg: size enum (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, lane-offset constants.
- Sub-module dmem_lane_merge (combinational):
  - store merge: old word, wdata, size, offset → new word;
  - load extract/extend: word, size, offset, unsigned → result.
- The top module holds the arbiter, FSM, and response registers.

## Test plan
- **Word store then load.** P0 stores 0xDEADBEEF to 0x10, then loads word 0x10 → RVALID at T+1 with RDATA = 0xDEADBEEF, ERR = 0.
- **Sub-word store.** Word 0x20 = 0x11223344. P0 stores byte 0xAA to 0x21 → MEM_WE only at T+1, MEM_WD = 0x1122AA44. Both READY = 0 at T+1. RVALID at T+2.
- **Load extension.** Word at 0x30 = 0x0000F080. Load byte 0x30 signed → 0xFFFFFF80. Byte unsigned → 0x00000080. Half signed at 0x30 → 0xFFFFF080.
- **Arbitration.** Both ports valid for 4 cycles after reset, word loads → grants P0, P1, P0, P1. Each RVALID returns on the matching port with the correct data.
- **Error cases.**
  - Word load at 0x02 → ERR = 1.
  - Half store at 0x01 → ERR = 1, MEM_WE stays 0.
  - Address 0x1000 → ERR = 1.
  - SIZE = 11 → ERR = 1.
- **Reset during RMW.** Assert RST during the RMW cycle of a byte store to 0x40 → no write, no RVALID. After release, a load of 0x40 returns the old value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and lane constants for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_e;

    // Byte lanes are little-endian: lane n occupies bits [8n +: 8].
    localparam int         BYTE_W        = 8;
    localparam int         HALF_W        = 16;
    localparam logic [1:0] HALF_OFS_MASK = 2'b10;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester bus and memory bus for the data-memory arbiter.
interface dmem_req_if #(
    parameter int REG_BITS = 32
);
    logic                valid;
    logic                ready;
    logic [REG_BITS-1:0] addr;
    logic                we;
    logic [1:0]          size;
    logic                is_unsigned;
    logic [REG_BITS-1:0] wdata;
    logic                rvalid;
    logic [REG_BITS-1:0] rdata;
    logic                err;

    modport master (
        output valid, addr, we, size, is_unsigned, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, addr, we, size, is_unsigned, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

interface dmem_mem_if #(
    parameter int REG_BITS = 32,
    parameter int IDX_BITS = 10
);
    logic [IDX_BITS-1:0] a;
    logic [REG_BITS-1:0] wd;
    logic                we;
    logic [REG_BITS-1:0] rd;

    modport master (
        output a, wd, we,
        input  rd
    );

    modport slave (
        input  a, wd, we,
        output rd
    );
endinterface

// File: rtl/dmem_lane_merge.sv
// Byte/half lane handling: store merge into an old word, load extract and extend.
module dmem_lane_merge
    import dmem_pkg::*;
#(
    parameter int REG_BITS = 32
) (
    input  logic [REG_BITS-1:0] old_word,
    input  logic [REG_BITS-1:0] st_data,
    input  size_e               st_size,
    input  logic [1:0]          st_offset,
    output logic [REG_BITS-1:0] merged,
    input  logic [REG_BITS-1:0] ld_word,
    input  size_e               ld_size,
    input  logic [1:0]          ld_offset,
    input  logic                ld_unsigned,
    output logic [REG_BITS-1:0] ld_result
);

    localparam int SHW = $clog2(REG_BITS);

    logic [SHW-1:0]      st_b_shift;
    logic [SHW-1:0]      st_h_shift;
    logic [SHW-1:0]      ld_b_shift;
    logic [SHW-1:0]      ld_h_shift;
    logic [REG_BITS-1:0] mask;
    logic [HALF_W-1:0]   lane;

    // Halves always sit on an even lane, so bit 0 of the offset is ignored for them.
    assign st_b_shift = SHW'({st_offset, 3'b000});
    assign st_h_shift = SHW'({st_offset & HALF_OFS_MASK, 3'b000});
    assign ld_b_shift = SHW'({ld_offset, 3'b000});
    assign ld_h_shift = SHW'({ld_offset & HALF_OFS_MASK, 3'b000});

    // Replace the addressed lane of the old word with the low bits of the store data.
    always_comb begin
        mask   = '0;
        merged = st_data;
        case (st_size)
            SZ_BYTE: begin
                mask   = REG_BITS'({BYTE_W{1'b1}}) << st_b_shift;
                merged = (old_word & ~mask) | (REG_BITS'(st_data[BYTE_W-1:0]) << st_b_shift);
            end
            SZ_HALF: begin
                mask   = REG_BITS'({HALF_W{1'b1}}) << st_h_shift;
                merged = (old_word & ~mask) | (REG_BITS'(st_data[HALF_W-1:0]) << st_h_shift);
            end
            default: merged = st_data;
        endcase
    end

    // Pull the addressed lane down to bit 0 and sign- or zero-extend it.
    always_comb begin
        lane      = '0;
        ld_result = ld_word;
        case (ld_size)
            SZ_BYTE: begin
                lane      = HALF_W'(ld_word >> ld_b_shift);
                ld_result = {{(REG_BITS-BYTE_W){~ld_unsigned & lane[BYTE_W-1]}}, lane[BYTE_W-1:0]};
            end
            SZ_HALF: begin
                lane      = HALF_W'(ld_word >> ld_h_shift);
                ld_result = {{(REG_BITS-HALF_W){~ld_unsigned & lane[HALF_W-1]}}, lane};
            end
            default: ld_result = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and word-access sequencer for the data memory.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int REG_BITS  = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic    clk,
    input  logic    rst,
    dmem_req_if.slave  p0,
    dmem_req_if.slave  p1,
    dmem_mem_if.master mem
);

    localparam int IDX_BITS = $clog2(MEM_WORDS);

    state_e                       state_q, state_d;
    logic                         last_q, last_d;
    logic [1:0]                   rvalid_q, rvalid_d;
    logic [1:0]                   err_q, err_d;
    logic [1:0][REG_BITS-1:0]     rdata_q, rdata_d;
    logic [REG_BITS-1:0]          old_q, old_d;
    logic [REG_BITS-1:0]          wdata_q, wdata_d;
    logic [IDX_BITS-1:0]          idx_q, idx_d;
    logic [1:0]                   ofs_q, ofs_d;
    size_e                        size_q, size_d;
    logic                         port_q, port_d;

    logic                         grant_valid;
    logic                         grant;
    logic [REG_BITS-1:0]          req_addr;
    logic                         req_we;
    size_e                        req_size;
    logic                         req_uns;
    logic [REG_BITS-1:0]          req_wdata;
    logic                         req_err;

    logic [IDX_BITS-1:0]          mem_a;
    logic [REG_BITS-1:0]          mem_wd;
    logic                         mem_we;
    logic [REG_BITS-1:0]          merged;
    logic [REG_BITS-1:0]          ld_result;

    // Round-robin grant: a lone requester wins, on conflict the port other than LAST wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (state_q == ST_IDLE && !rst) begin
            if (p0.valid && p1.valid) begin
                grant_valid = 1'b1;
                grant       = ~last_q;
            end else if (p0.valid) begin
                grant_valid = 1'b1;
                grant       = 1'b0;
            end else if (p1.valid) begin
                grant_valid = 1'b1;
                grant       = 1'b1;
            end
        end
    end

    assign p0.ready = grant_valid & ~grant;
    assign p1.ready = grant_valid &  grant;

    assign req_addr  = grant ? p1.addr        : p0.addr;
    assign req_we    = grant ? p1.we          : p0.we;
    assign req_size  = size_e'(grant ? p1.size : p0.size);
    assign req_uns   = grant ? p1.is_unsigned : p0.is_unsigned;
    assign req_wdata = grant ? p1.wdata       : p0.wdata;

    assign req_err = (req_size == SZ_ILLEGAL)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                   | (|req_addr[REG_BITS-1:2+IDX_BITS]);

    dmem_lane_merge #(.REG_BITS(REG_BITS)) u_lane (
        .old_word    (old_q),
        .st_data     (wdata_q),
        .st_size     (size_q),
        .st_offset   (ofs_q),
        .merged      (merged),
        .ld_word     (mem.rd),
        .ld_size     (req_size),
        .ld_offset   (req_addr[1:0]),
        .ld_unsigned (req_uns),
        .ld_result   (ld_result)
    );

    // Next state, memory drive and response capture for IDLE accepts and the RMW write.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        rvalid_d = '0;
        err_d    = '0;
        rdata_d  = '0;
        old_d    = old_q;
        wdata_d  = wdata_q;
        idx_d    = idx_q;
        ofs_d    = ofs_q;
        size_d   = size_q;
        port_d   = port_q;
        mem_a    = req_addr[2 +: IDX_BITS];
        mem_wd   = req_wdata;
        mem_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    last_d = grant;
                    if (req_err) begin
                        rvalid_d[grant] = 1'b1;
                        err_d[grant]    = 1'b1;
                    end else if (!req_we) begin
                        rvalid_d[grant] = 1'b1;
                        rdata_d[grant]  = ld_result;
                    end else if (req_size == SZ_WORD) begin
                        mem_we          = 1'b1;
                        rvalid_d[grant] = 1'b1;
                    end else begin
                        old_d   = mem.rd;
                        wdata_d = req_wdata;
                        idx_d   = req_addr[2 +: IDX_BITS];
                        ofs_d   = req_addr[1:0];
                        size_d  = req_size;
                        port_d  = grant;
                        state_d = ST_RMW;
                    end
                end
            end
            ST_RMW: begin
                // A reset landing here drops the write; the flops clear the response.
                mem_a            = idx_q;
                mem_wd           = merged;
                mem_we           = ~rst;
                rvalid_d[port_q] = 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem.a  = mem_a;
    assign mem.wd = mem_wd;
    assign mem.we = mem_we;

    // State, round-robin pointer, RMW context and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            old_q    <= '0;
            wdata_q  <= '0;
            idx_q    <= '0;
            ofs_q    <= '0;
            size_q   <= SZ_BYTE;
            port_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            old_q    <= old_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            ofs_q    <= ofs_d;
            size_q   <= size_d;
            port_q   <= port_d;
        end
    end

    assign p0.rvalid = rvalid_q[0];
    assign p0.err    = err_q[0];
    assign p0.rdata  = rdata_q[0];
    assign p1.rvalid = rvalid_q[1];
    assign p1.err    = err_q[1];
    assign p1.rdata  = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-addressed reference memory and queue-based response model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_req_if p0_if ();
    dmem_req_if p1_if ();
    dmem_mem_if mem_if ();

    dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .p0  (p0_if),
        .p1  (p1_if),
        .mem (mem_if)
    );

    // Physical memory seen by the DUT: async read, write on rising edge.
    logic [31:0] phys_mem [1024] = '{default: 32'h0};
    assign mem_if.rd = phys_mem[mem_if.a];
    always @(posedge clk) if (mem_if.we) phys_mem[mem_if.a] <= mem_if.wd;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    req_t        reqq0[$], reqq1[$];
    rsp_t        rspq0[$], rspq1[$];
    logic [7:0]  ref_b [4096] = '{default: 8'h0};
    int          grant_log[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    int          m_last = 1;
    bit          m_busy = 0;
    req_t        m_pend;
    int          m_pend_port = 0;
    bit          rst_in_cycle = 0;

    logic [31:0] last_rsp_data [2];
    logic        last_rsp_err  [2];
    int          last_rsp_cyc  [2];
    int          last_acc_cyc  [2];
    int          n_rv          [2];
    int          last_we_cyc = 0;
    logic [31:0] last_we_wd = 0;
    int          n_we = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit req_is_err(input req_t r);
        return (r.size == 2'd3) || (r.size == 2'd1 && r.addr[0]) ||
               (r.size == 2'd2 && r.addr[1:0] != 2'd0) || (r.addr >= 32'h1000);
    endfunction

    function automatic int req_bytes(input req_t r);
        return 1 << r.size;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int a = int'(addr & 32'hFFC);
        return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
    endfunction

    function automatic logic [31:0] ref_load(input req_t r);
        int          a = int'(r.addr);
        int          n = req_bytes(r);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[a+i]) << (8 * i));
        if (!r.uns && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input req_t r);
        int a = int'(r.addr);
        for (int i = 0; i < req_bytes(r); i++) ref_b[a+i] = 8'(r.wdata >> (8 * i));
    endtask

    task automatic push_rsp(input int p, input int due, input logic [31:0] d, input logic e);
        rsp_t x;
        x.due = due; x.data = d; x.err = e;
        if (p == 0) rspq0.push_back(x); else rspq1.push_back(x);
    endtask

    task automatic drive_ports();
        p0_if.valid = (reqq0.size() > 0);
        p1_if.valid = (reqq1.size() > 0);
        if (reqq0.size() > 0) begin
            p0_if.addr = reqq0[0].addr; p0_if.we = reqq0[0].we; p0_if.size = reqq0[0].size;
            p0_if.is_unsigned = reqq0[0].uns; p0_if.wdata = reqq0[0].wdata;
        end else begin
            p0_if.addr = 0; p0_if.we = 0; p0_if.size = 0; p0_if.is_unsigned = 0; p0_if.wdata = 0;
        end
        if (reqq1.size() > 0) begin
            p1_if.addr = reqq1[0].addr; p1_if.we = reqq1[0].we; p1_if.size = reqq1[0].size;
            p1_if.is_unsigned = reqq1[0].uns; p1_if.wdata = reqq1[0].wdata;
        end else begin
            p1_if.addr = 0; p1_if.we = 0; p1_if.size = 0; p1_if.is_unsigned = 0; p1_if.wdata = 0;
        end
    endtask

    // Predict this cycle's grant and memory write, check the combinational outputs.
    task automatic model_cycle();
        bit          exp_r0 = 0, exp_r1 = 0, exp_we = 0, chk_a = 0;
        logic [31:0] exp_wd = 0, exp_a = 0;
        req_t        r;
        int          g = -1;
        bit          v0 = (reqq0.size() > 0);
        bit          v1 = (reqq1.size() > 0);

        if (p0_if.ready) begin grant_log.push_back(0); last_acc_cyc[0] = cyc; end
        if (p1_if.ready) begin grant_log.push_back(1); last_acc_cyc[1] = cyc; end
        if (mem_if.we) begin last_we_cyc = cyc; last_we_wd = mem_if.wd; n_we++; end

        if (rst) begin
            m_busy = 0;
            m_last = 1;
            rst_in_cycle = 1;
        end else if (m_busy) begin
            ref_store(m_pend);
            exp_we = 1; exp_wd = ref_word(m_pend.addr);
            chk_a = 1;  exp_a = 32'(m_pend.addr[11:2]);
            push_rsp(m_pend_port, cyc + 1, 0, 0);
            m_busy = 0;
        end else begin
            if (v0 && v1) g = (m_last == 0) ? 1 : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
            if (g >= 0) begin
                if (g == 0) begin r = reqq0.pop_front(); exp_r0 = 1; end
                else        begin r = reqq1.pop_front(); exp_r1 = 1; end
                m_last = g;
                if (req_is_err(r)) begin
                    push_rsp(g, cyc + 1, 0, 1);
                end else begin
                    chk_a = 1; exp_a = 32'(r.addr[11:2]);
                    if (!r.we) begin
                        push_rsp(g, cyc + 1, ref_load(r), 0);
                    end else if (r.size == 2'd2) begin
                        exp_we = 1; exp_wd = r.wdata;
                        ref_store(r);
                        push_rsp(g, cyc + 1, 0, 0);
                    end else begin
                        m_busy = 1; m_pend = r; m_pend_port = g;
                    end
                end
            end
        end

        chk_eq("p0_ready", p0_if.ready, exp_r0);
        chk_eq("p1_ready", p1_if.ready, exp_r1);
        chk_eq("mem_we", mem_if.we, exp_we);
        if (exp_we) chk_eq("mem_wd", mem_if.wd, exp_wd);
        if (chk_a)  chk_eq("mem_a", 32'(mem_if.a), exp_a);
    endtask

    task automatic check_port(input int p);
        logic        rv = (p == 0) ? p0_if.rvalid : p1_if.rvalid;
        logic [31:0] rd = (p == 0) ? p0_if.rdata  : p1_if.rdata;
        logic        er = (p == 0) ? p0_if.err    : p1_if.err;
        bit          exp_v = 0;
        rsp_t        x;
        if (p == 0 && rspq0.size() > 0 && rspq0[0].due == cyc) begin exp_v = 1; x = rspq0.pop_front(); end
        if (p == 1 && rspq1.size() > 0 && rspq1[0].due == cyc) begin exp_v = 1; x = rspq1.pop_front(); end
        chk_eq(p == 0 ? "p0_rvalid" : "p1_rvalid", rv, exp_v);
        if (rv) begin
            last_rsp_data[p] = rd; last_rsp_err[p] = er; last_rsp_cyc[p] = cyc; n_rv[p]++;
        end
        if (exp_v) begin
            chk_eq(p == 0 ? "p0_rdata" : "p1_rdata", rd, x.data);
            chk_eq(p == 0 ? "p0_err" : "p1_err", er, x.err);
        end
    endtask

    task automatic run_cycle();
        drive_ports();
        @(negedge clk); #1;
        model_cycle();
        @(posedge clk); #1;
        cyc++;
        if (rst_in_cycle) begin
            rspq0.delete(); rspq1.delete();
            rst_in_cycle = 0;
        end
        check_port(0);
        check_port(1);
    endtask

    task automatic drain();
        int n = 0;
        while ((reqq0.size() + reqq1.size() + rspq0.size() + rspq1.size() > 0 || m_busy) && n < 60) begin
            run_cycle();
            n++;
        end
        chk_eq("drain_pending", 32'(reqq0.size() + reqq1.size() + rspq0.size() + rspq1.size()), 0);
    endtask

    task automatic push_req(input int p, input logic [31:0] addr, input logic we,
                            input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        req_t r;
        r.addr = addr; r.we = we; r.size = size; r.uns = uns; r.wdata = wdata;
        if (p == 0) reqq0.push_back(r); else reqq1.push_back(r);
    endtask

    task automatic push_random(input int p);
        logic [31:0] a    = 32'($urandom_range(0, 63));
        logic [1:0]  sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
        if ($urandom_range(0, 15) == 0) a = a + 32'h1000 * $urandom_range(1, 1000);
        push_req(p, a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom);
    endtask

    initial begin
        int snap_rv;
        int snap_we;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle();
        chk_eq("reset_p0_rvalid", p0_if.rvalid, 0);
        chk_eq("reset_p1_err", p1_if.err, 0);
        chk_eq("reset_p0_rdata", p0_if.rdata, 0);
        rst = 1'b0;

        // Word store then load.
        push_req(0, 32'h10, 1, 2'd2, 0, 32'hDEADBEEF);
        push_req(0, 32'h10, 0, 2'd2, 0, 0);
        drain();
        chk_eq("word_load_data", last_rsp_data[0], 32'hDEADBEEF);
        chk_eq("word_load_err", last_rsp_err[0], 0);
        chk_eq("word_load_latency", 32'(last_rsp_cyc[0] - last_acc_cyc[0]), 1);

        // Sub-word store as read-modify-write.
        push_req(0, 32'h20, 1, 2'd2, 0, 32'h11223344);
        drain();
        push_req(0, 32'h21, 1, 2'd0, 0, 32'h000000AA);
        drain();
        chk_eq("rmw_wd", last_we_wd, 32'h1122AA44);
        chk_eq("rmw_we_cycle", 32'(last_we_cyc - last_acc_cyc[0]), 1);
        chk_eq("rmw_rvalid_cycle", 32'(last_rsp_cyc[0] - last_acc_cyc[0]), 2);

        // Load extension.
        push_req(0, 32'h30, 1, 2'd2, 0, 32'h0000F080);
        push_req(0, 32'h30, 0, 2'd0, 0, 0);
        drain();
        chk_eq("ld_byte_signed", last_rsp_data[0], 32'hFFFFFF80);
        push_req(0, 32'h30, 0, 2'd0, 1, 0);
        drain();
        chk_eq("ld_byte_unsigned", last_rsp_data[0], 32'h00000080);
        push_req(0, 32'h30, 0, 2'd1, 0, 0);
        drain();
        chk_eq("ld_half_signed", last_rsp_data[0], 32'hFFFFF080);

        // Arbitration right after reset.
        rst = 1'b1;
        run_cycle(); run_cycle();
        rst = 1'b0;
        grant_log.delete();
        push_req(0, 32'h10, 0, 2'd2, 0, 0);
        push_req(0, 32'h20, 0, 2'd2, 0, 0);
        push_req(1, 32'h30, 0, 2'd2, 0, 0);
        push_req(1, 32'h20, 0, 2'd2, 0, 0);
        drain();
        chk_eq("arb_grants", 32'(grant_log.size()), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++) chk_eq("arb_order", 32'(grant_log[i]), 32'(i % 2));
        chk_eq("arb_p0_data", last_rsp_data[0], 32'h1122AA44);
        chk_eq("arb_p1_data", last_rsp_data[1], 32'h1122AA44);

        // Error cases.
        snap_we = n_we;
        push_req(0, 32'h02, 0, 2'd2, 0, 0);
        drain();
        chk_eq("err_misaligned_word", last_rsp_err[0], 1);
        push_req(1, 32'h01, 1, 2'd1, 0, 32'h5555);
        drain();
        chk_eq("err_half_store", last_rsp_err[1], 1);
        chk_eq("err_half_store_rdata", last_rsp_data[1], 0);
        push_req(0, 32'h1000, 0, 2'd2, 0, 0);
        drain();
        chk_eq("err_range", last_rsp_err[0], 1);
        push_req(1, 32'h08, 1, 2'd3, 0, 32'h1234);
        drain();
        chk_eq("err_size", last_rsp_err[1], 1);
        chk_eq("err_no_writes", 32'(n_we - snap_we), 0);

        // Reset during the RMW cycle of a byte store.
        push_req(0, 32'h40, 1, 2'd2, 0, 32'hCAFEF00D);
        drain();
        snap_rv = n_rv[0];
        snap_we = n_we;
        push_req(0, 32'h40, 1, 2'd0, 0, 32'h00000055);
        run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        run_cycle(); run_cycle();
        chk_eq("rst_rmw_no_rvalid", 32'(n_rv[0] - snap_rv), 0);
        chk_eq("rst_rmw_no_write", 32'(n_we - snap_we), 0);
        push_req(0, 32'h40, 0, 2'd2, 0, 0);
        drain();
        chk_eq("rst_rmw_old_value", last_rsp_data[0], 32'hCAFEF00D);

        // Randomized traffic on both ports.
        for (int i = 0; i < 1500; i++) begin
            if (reqq0.size() == 0 && $urandom_range(0, 9) < 6) push_random(0);
            if (reqq1.size() == 0 && $urandom_range(0, 9) < 6) push_random(1);
            run_cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
